commit_bundle_gen: RTL and testbench

- Retire-side producer of the per-cycle commit bundle (rat_write_en plus four addr/phys/data lanes) that the commit/DPI sink consumes.
- Each cycle it examines the 4 oldest ROB entries and retires the longest in-order prefix that is complete and exception-free.
- It pops those entries, drives the architectural RAT-write bundle, and releases old physical registers to the freelist.
- An exception at the ROB head triggers a flush sequence.

---
 rtl/commit_pkg.sv | 24 ++
 rtl/commit_prefix_sel.sv | 29 ++
 rtl/commit_bundle_gen.sv | 148 ++++++++++++++
 tb/tb_commit_bundle_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/commit_pkg.sv
// Shared types for the retire-side commit bundle generator.
// Lane struct, FSM state and sizing constants.
package commit_pkg;

  localparam int COMMIT_W     = 4;
  localparam int PREG_W       = 8;
  localparam int FLUSH_CYCLES = 3;
  localparam int CNT_W        = 2;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    FLUSH_WAIT
  } state_t;

  typedef struct packed {
    logic              en;
    logic [4:0]        rd;
    logic [PREG_W-1:0] pdst;
    logic [PREG_W-1:0] old_pdst;
    logic [31:0]       data;
  } lane_t;

endpackage

// File: rtl/commit_prefix_sel.sv
// In-order retire prefix: a slot commits only if it and
// every older slot are valid, done and exception-free.
module commit_prefix_sel
  import commit_pkg::*;
(
  input  logic [COMMIT_W-1:0] valid,
  input  logic [COMMIT_W-1:0] done,
  input  logic [COMMIT_W-1:0] exc,
  output logic [COMMIT_W-1:0] mask,
  output logic [2:0]          cnt
);

  logic [COMMIT_W-1:0] ok;
  logic                run;

  assign ok = valid & done & ~exc;

  always_comb begin
    run  = 1'b1;
    mask = '0;
    cnt  = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      run     = run & ok[i];
      mask[i] = run;
      if (run) cnt = cnt + 3'd1;
    end
  end

endmodule

// File: rtl/commit_bundle_gen.sv
// Retires up to four ROB head entries per cycle and drives the
// registered RAT-write / freelist bundle; sequences head flushes.
module commit_bundle_gen
  import commit_pkg::*;
(
  input  logic         clock,
  input  logic         rst,
  input  logic [3:0]   head_valid,
  input  logic [3:0]   head_done,
  input  logic [3:0]   head_exc,
  input  logic [3:0]   head_rd_wen,
  input  logic [19:0]  head_rd,
  input  logic [31:0]  head_pdst,
  input  logic [31:0]  head_old_pdst,
  input  logic [127:0] head_result,
  input  logic [31:0]  head_pc0,
  output logic [2:0]   rob_deq_cnt,
  output logic [7:0]   rat_write_en,
  output logic [7:0]   rat_write_addr_0,
  output logic [7:0]   rat_write_addr_1,
  output logic [7:0]   rat_write_addr_2,
  output logic [7:0]   rat_write_addr_3,
  output logic [7:0]   rat_write_data_0,
  output logic [7:0]   rat_write_data_1,
  output logic [7:0]   rat_write_data_2,
  output logic [7:0]   rat_write_data_3,
  output logic [31:0]  reg_write_data_0,
  output logic [31:0]  reg_write_data_1,
  output logic [31:0]  reg_write_data_2,
  output logic [31:0]  reg_write_data_3,
  output logic [3:0]   free_en,
  output logic [7:0]   free_preg_0,
  output logic [7:0]   free_preg_1,
  output logic [7:0]   free_preg_2,
  output logic [7:0]   free_preg_3,
  output logic         flush,
  output logic [31:0]  flush_pc,
  output logic         busy_flush
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       mask;
  logic [2:0]       pcnt;
  logic             take_exc;
  lane_t            lane_d [COMMIT_W];
  lane_t            lane_q [COMMIT_W];
  logic [3:0]       en_q;

  commit_prefix_sel u_sel (
    .valid (head_valid),
    .done  (head_done),
    .exc   (head_exc),
    .mask  (mask),
    .cnt   (pcnt)
  );

  assign take_exc = (state == RUN) & head_valid[0]
                  & head_done[0] & head_exc[0];

  assign rob_deq_cnt = (state == RUN) ? pcnt : 3'd0;
  assign flush       = (state == FLUSH);
  assign busy_flush  = (state == FLUSH_WAIT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN: begin
        if (take_exc) state_nxt = FLUSH;
      end
      FLUSH: begin
        state_nxt = FLUSH_WAIT;
        cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
      end
      FLUSH_WAIT: begin
        if (cnt == '0) state_nxt = RUN;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Disabled lanes are zeroed so nothing stale reaches the sink.
  always_comb begin
    for (int i = 0; i < COMMIT_W; i++) begin
      lane_d[i] = '0;
      if (state == RUN && mask[i] && head_rd_wen[i]
          && head_rd[i*5 +: 5] != 5'd0) begin
        lane_d[i].en       = 1'b1;
        lane_d[i].rd       = head_rd[i*5 +: 5];
        lane_d[i].pdst     = head_pdst[i*PREG_W +: PREG_W];
        lane_d[i].old_pdst = head_old_pdst[i*PREG_W +: PREG_W];
        lane_d[i].data     = head_result[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < COMMIT_W; i++) lane_q[i] <= '0;
    end else begin
      for (int i = 0; i < COMMIT_W; i++) lane_q[i] <= lane_d[i];
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst)          flush_pc <= '0;
    else if (take_exc) flush_pc <= head_pc0;
  end

  assign en_q = {lane_q[3].en, lane_q[2].en,
                 lane_q[1].en, lane_q[0].en};

  assign rat_write_en = {4'b0, en_q};
  assign free_en      = en_q;

  assign rat_write_addr_0 = {3'b0, lane_q[0].rd};
  assign rat_write_addr_1 = {3'b0, lane_q[1].rd};
  assign rat_write_addr_2 = {3'b0, lane_q[2].rd};
  assign rat_write_addr_3 = {3'b0, lane_q[3].rd};

  assign rat_write_data_0 = lane_q[0].pdst;
  assign rat_write_data_1 = lane_q[1].pdst;
  assign rat_write_data_2 = lane_q[2].pdst;
  assign rat_write_data_3 = lane_q[3].pdst;

  assign reg_write_data_0 = lane_q[0].data;
  assign reg_write_data_1 = lane_q[1].data;
  assign reg_write_data_2 = lane_q[2].data;
  assign reg_write_data_3 = lane_q[3].data;

  assign free_preg_0 = lane_q[0].old_pdst;
  assign free_preg_1 = lane_q[1].old_pdst;
  assign free_preg_2 = lane_q[2].old_pdst;
  assign free_preg_3 = lane_q[3].old_pdst;

endmodule

// File: tb/tb_commit_bundle_gen.sv
// Directed bench for commit_bundle_gen: prefix retire,
// zeroed lanes, rd=0, head flush sequence, async reset.
module tb_commit_bundle_gen;

  logic         clock;
  logic         rst;
  logic [3:0]   head_valid, head_done, head_exc, head_rd_wen;
  logic [19:0]  head_rd;
  logic [31:0]  head_pdst, head_old_pdst, head_pc0;
  logic [127:0] head_result;
  logic [2:0]   rob_deq_cnt;
  logic [7:0]   rat_write_en;
  logic [7:0]   rat_write_addr_0, rat_write_addr_1;
  logic [7:0]   rat_write_addr_2, rat_write_addr_3;
  logic [7:0]   rat_write_data_0, rat_write_data_1;
  logic [7:0]   rat_write_data_2, rat_write_data_3;
  logic [31:0]  reg_write_data_0, reg_write_data_1;
  logic [31:0]  reg_write_data_2, reg_write_data_3;
  logic [3:0]   free_en;
  logic [7:0]   free_preg_0, free_preg_1;
  logic [7:0]   free_preg_2, free_preg_3;
  logic         flush;
  logic [31:0]  flush_pc;
  logic         busy_flush;

  int checks = 0;
  int errors = 0;

  commit_bundle_gen dut (
    .clock            (clock),
    .rst              (rst),
    .head_valid       (head_valid),
    .head_done        (head_done),
    .head_exc         (head_exc),
    .head_rd_wen      (head_rd_wen),
    .head_rd          (head_rd),
    .head_pdst        (head_pdst),
    .head_old_pdst    (head_old_pdst),
    .head_result      (head_result),
    .head_pc0         (head_pc0),
    .rob_deq_cnt      (rob_deq_cnt),
    .rat_write_en     (rat_write_en),
    .rat_write_addr_0 (rat_write_addr_0),
    .rat_write_addr_1 (rat_write_addr_1),
    .rat_write_addr_2 (rat_write_addr_2),
    .rat_write_addr_3 (rat_write_addr_3),
    .rat_write_data_0 (rat_write_data_0),
    .rat_write_data_1 (rat_write_data_1),
    .rat_write_data_2 (rat_write_data_2),
    .rat_write_data_3 (rat_write_data_3),
    .reg_write_data_0 (reg_write_data_0),
    .reg_write_data_1 (reg_write_data_1),
    .reg_write_data_2 (reg_write_data_2),
    .reg_write_data_3 (reg_write_data_3),
    .free_en          (free_en),
    .free_preg_0      (free_preg_0),
    .free_preg_1      (free_preg_1),
    .free_preg_2      (free_preg_2),
    .free_preg_3      (free_preg_3),
    .flush            (flush),
    .flush_pc         (flush_pc),
    .busy_flush       (busy_flush)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic head(input logic [3:0] v, input logic [3:0] d,
                      input logic [3:0] e, input logic [3:0] w);
    head_valid  = v;
    head_done   = d;
    head_exc    = e;
    head_rd_wen = w;
  endtask

  // rd 1..4, pdst 0x21..0x24, old 0x11..0x14, result 0x1000+i
  task automatic std_lanes();
    head_rd       = {5'd4, 5'd3, 5'd2, 5'd1};
    head_pdst     = 32'h24232221;
    head_old_pdst = 32'h14131211;
    head_result   = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
  endtask

  initial begin
    rst = 1'b0;
    head(4'h0, 4'h0, 4'h0, 4'h0);
    head_rd = '0; head_pdst = '0; head_old_pdst = '0;
    head_result = '0; head_pc0 = '0;
    #2;
    chk("rst_en",    32'(rat_write_en), 32'h0);
    chk("rst_free",  32'(free_en),      32'h0);
    chk("rst_flush", 32'(flush),        32'h0);
    chk("rst_busy",  32'(busy_flush),   32'h0);
    chk("rst_pc",    flush_pc,          32'h0);
    #10 rst = 1'b1;
    step();

    // all four retire
    head(4'hF, 4'hF, 4'h0, 4'hF);
    std_lanes();
    #1 chk("t1_deq", 32'(rob_deq_cnt), 32'd4);
    step();
    chk("t1_en",   32'(rat_write_en), 32'h0F);
    chk("t1_a0",   32'(rat_write_addr_0), 32'd1);
    chk("t1_a3",   32'(rat_write_addr_3), 32'd4);
    chk("t1_d0",   32'(rat_write_data_0), 32'h21);
    chk("t1_d1",   32'(rat_write_data_1), 32'h22);
    chk("t1_d2",   32'(rat_write_data_2), 32'h23);
    chk("t1_d3",   32'(rat_write_data_3), 32'h24);
    chk("t1_r3",   reg_write_data_3, 32'h1003);
    chk("t1_free", 32'(free_en), 32'hF);
    chk("t1_fp0",  32'(free_preg_0), 32'h11);
    chk("t1_fp2",  32'(free_preg_2), 32'h13);

    // entry 2 not done
    head(4'hF, 4'b1011, 4'h0, 4'hF);
    #1 chk("t2_deq", 32'(rob_deq_cnt), 32'd2);
    step();
    chk("t2_en",   32'(rat_write_en), 32'h03);
    chk("t2_a1",   32'(rat_write_addr_1), 32'd2);
    chk("t2_a2",   32'(rat_write_addr_2), 32'd0);
    chk("t2_d3",   32'(rat_write_data_3), 32'd0);
    chk("t2_r2",   reg_write_data_2, 32'd0);
    chk("t2_fp3",  32'(free_preg_3), 32'd0);
    chk("t2_free", 32'(free_en), 32'h3);

    // entry 1 has rd = 0
    head(4'hF, 4'hF, 4'h0, 4'hF);
    head_rd = {5'd4, 5'd3, 5'd0, 5'd1};
    #1 chk("t3_deq", 32'(rob_deq_cnt), 32'd4);
    step();
    chk("t3_en",   32'(rat_write_en), 32'h0D);
    chk("t3_free", 32'(free_en), 32'hD);
    chk("t3_a1",   32'(rat_write_addr_1), 32'd0);
    chk("t3_d1",   32'(rat_write_data_1), 32'd0);
    chk("t3_r2",   reg_write_data_2, 32'h1002);

    // idle cycle clears the bundle
    head(4'h0, 4'h0, 4'h0, 4'h0);
    std_lanes();
    #1 chk("t4_deq", 32'(rob_deq_cnt), 32'd0);
    step();
    chk("t4_en", 32'(rat_write_en), 32'h0);
    chk("t4_d0", 32'(rat_write_data_0), 32'h0);

    // head exception
    head(4'hF, 4'hF, 4'h1, 4'hF);
    head_pc0 = 32'h80000010;
    #1 chk("t5_deq", 32'(rob_deq_cnt), 32'd0);
    step();
    head(4'hF, 4'hF, 4'h0, 4'hF);
    #1;
    chk("t5_flush", 32'(flush), 32'd1);
    chk("t5_pc",    flush_pc, 32'h80000010);
    chk("t5_en",    32'(rat_write_en), 32'h0);
    chk("t5_fdeq",  32'(rob_deq_cnt), 32'd0);
    chk("t5_fbusy", 32'(busy_flush), 32'd0);
    head_pc0 = 32'h0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5_busy", 32'(busy_flush), 32'd1);
      chk("t5_nofl", 32'(flush), 32'd0);
      chk("t5_wdeq", 32'(rob_deq_cnt), 32'd0);
      chk("t5_wen",  32'(rat_write_en), 32'h0);
    end
    step();
    chk("t5_run",  32'(busy_flush), 32'd0);
    chk("t5_rdeq", 32'(rob_deq_cnt), 32'd4);
    chk("t5_hold", flush_pc, 32'h80000010);
    step();
    chk("t5_ren",  32'(rat_write_en), 32'h0F);

    // exception in slot 2, later reaches head
    head(4'hF, 4'hF, 4'b0100, 4'hF);
    #1 chk("t6_deq", 32'(rob_deq_cnt), 32'd2);
    step();
    chk("t6_en", 32'(rat_write_en), 32'h03);
    head(4'h3, 4'h3, 4'h1, 4'h3);
    head_pc0 = 32'h80000040;
    #1 chk("t6_hdeq", 32'(rob_deq_cnt), 32'd0);
    step();
    chk("t6_flush", 32'(flush), 32'd1);
    chk("t6_pc",    flush_pc, 32'h80000040);
    step();
    chk("t6_busy",  32'(busy_flush), 32'd1);

    // async reset mid FLUSH_WAIT
    #2 rst = 1'b0;
    #1;
    chk("t7_busy", 32'(busy_flush), 32'd0);
    chk("t7_pc",   flush_pc, 32'h0);
    chk("t7_en",   32'(rat_write_en), 32'h0);
    chk("t7_fl",   32'(flush), 32'd0);
    #2 rst = 1'b1;
    head(4'hF, 4'hF, 4'h0, 4'hF);
    #1 chk("t7_deq", 32'(rob_deq_cnt), 32'd4);
    step();
    chk("t7_ren",  32'(rat_write_en), 32'h0F);
    chk("t7_a2",   32'(rat_write_addr_2), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
